// File: rtl/psg_mixer.sv
// -----------------------------------------------------------------------------
// psg_mixer
//   Stereo mixer and 4-sample averager for the three channels of a PSG.
//   On each CE strobe one sample per channel is mixed into a left and a
//   right value according to the pan mode:
//     00/11 mono : L = R = A+B+C
//     01    ABC  : L = 2A+B, R = 2C+B
//     10    ACB  : L = 2A+C, R = 2B+C
//   Four consecutive samples form a block. Their average (sum >> 2,
//   truncated) is registered on left_o/right_o one clock after the 4th CE,
//   and valid_o pulses for that one clock.
//
//   Optional feature: macro PSG_MIXER_DSM_EN adds a first-order sigma-delta
//   modulator per side, producing 1-bit DAC bitstreams.
//
// Ports
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   ce_i           sample strobe, one clk wide
//   ch_a_i/b/c     8-bit unsigned channel levels
//   stereo_i       pan mode, latched at the first CE of each block
//   mute_i         zeroes the block result; sampled on the block-closing CE
//   left_o/right_o 10-bit averaged mix, registered
//   valid_o        one-clk pulse when left_o/right_o update
//   dac_l_o/dac_r_o sigma-delta bitstreams (PSG_MIXER_DSM_EN only)
//
// Handshake: there is no back-pressure. valid_o is a pure strobe; the
// consumer must take left_o/right_o in the cycle valid_o is high (they hold
// until the next block closes anyway).
// -----------------------------------------------------------------------------
module psg_mixer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ce_i,
  input  logic [7:0] ch_a_i,
  input  logic [7:0] ch_b_i,
  input  logic [7:0] ch_c_i,
  input  logic [1:0] stereo_i,
  input  logic       mute_i,
  output logic [9:0] left_o,
  output logic [9:0] right_o,
  output logic       valid_o
`ifdef PSG_MIXER_DSM_EN
  ,
  output logic       dac_l_o,
  output logic       dac_r_o
`endif
);

  localparam logic [1:0] MODE_ABC = 2'b01;
  localparam logic [1:0] MODE_ACB = 2'b10;

  logic [1:0]  scnt_q, scnt_d;
  logic [1:0]  mode_q, mode_d;
  logic [11:0] acc_l_q, acc_l_d;
  logic [11:0] acc_r_q, acc_r_d;
  logic [9:0]  left_q, left_d;
  logic [9:0]  right_q, right_d;
  logic        valid_q, valid_d;

  logic [1:0]  eff_mode;
  logic [9:0]  a10, b10, c10;
  logic [9:0]  mix_l, mix_r;
  logic [11:0] sum_l, sum_r;

  // The first sample of a block must already use the mode being latched,
  // so the whole block sees one consistent mode.
  assign eff_mode = (scnt_q == 2'd0) ? stereo_i : mode_q;

  assign a10 = {2'b00, ch_a_i};
  assign b10 = {2'b00, ch_b_i};
  assign c10 = {2'b00, ch_c_i};

  always_comb begin
    mix_l = a10 + b10 + c10;
    mix_r = a10 + b10 + c10;
    case (eff_mode)
      MODE_ABC: begin
        mix_l = (a10 << 1) + b10;
        mix_r = (c10 << 1) + b10;
      end
      MODE_ACB: begin
        mix_l = (a10 << 1) + c10;
        mix_r = (b10 << 1) + c10;
      end
      default: ;
    endcase
  end

  // Max block sum is 4*765 = 3060, fits in 12 bits.
  assign sum_l = acc_l_q + {2'b00, mix_l};
  assign sum_r = acc_r_q + {2'b00, mix_r};

  always_comb begin
    scnt_d  = scnt_q;
    mode_d  = mode_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = 1'b0;
    if (ce_i) begin
      scnt_d = scnt_q + 2'd1;
      case (scnt_q)
        2'd0: begin
          mode_d  = stereo_i;
          acc_l_d = {2'b00, mix_l};
          acc_r_d = {2'b00, mix_r};
        end
        2'd1, 2'd2: begin
          acc_l_d = sum_l;
          acc_r_d = sum_r;
        end
        default: begin
          // Block close: accumulators are reloaded by the next block's
          // first CE, so they are left as is here.
          left_d  = mute_i ? 10'd0 : sum_l[11:2];
          right_d = mute_i ? 10'd0 : sum_r[11:2];
          valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scnt_q  <= 2'd0;
      mode_q  <= 2'b00;
      acc_l_q <= 12'd0;
      acc_r_q <= 12'd0;
      left_q  <= 10'd0;
      right_q <= 10'd0;
      valid_q <= 1'b0;
    end else begin
      scnt_q  <= scnt_d;
      mode_q  <= mode_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
    end
  end

  assign left_o  = left_q;
  assign right_o = right_q;
  assign valid_o = valid_q;

`ifdef PSG_MIXER_DSM_EN
  // First-order sigma-delta: the carry out of a 10-bit phase accumulator
  // is the output bit, so its density equals level/1024.
  logic [10:0] dsm_l_q, dsm_l_d;
  logic [10:0] dsm_r_q, dsm_r_d;

  assign dsm_l_d = {1'b0, dsm_l_q[9:0]} + {1'b0, left_q};
  assign dsm_r_d = {1'b0, dsm_r_q[9:0]} + {1'b0, right_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dsm_l_q <= 11'd0;
      dsm_r_q <= 11'd0;
    end else begin
      dsm_l_q <= dsm_l_d;
      dsm_r_q <= dsm_r_d;
    end
  end

  assign dac_l_o = dsm_l_q[10];
  assign dac_r_o = dsm_r_q[10];
`endif

endmodule

// File: tb/tb_psg_mixer.sv
// -----------------------------------------------------------------------------
// tb_psg_mixer
//   Self-checking bench for psg_mixer. A block-level reference model keeps
//   the running left/right sums of the current 4-sample block and pushes the
//   expected {left,right} result into exp_q when a block closes.
// -----------------------------------------------------------------------------
module tb_psg_mixer;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic [7:0] a, b, c;
  logic [1:0] st;
  logic       mu;
  logic [9:0] left_o, right_o;
  logic       valid_o;
`ifdef PSG_MIXER_DSM_EN
  logic       dac_l_o, dac_r_o;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int          m_cnt;
  logic [1:0]  m_mode;
  int          m_sl, m_sr;
  logic [19:0] exp_q[$];
  logic [19:0] exp_v;
  logic [9:0]  last_l, last_r;

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  psg_mixer dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .ce_i     (ce),
    .ch_a_i   (a),
    .ch_b_i   (b),
    .ch_c_i   (c),
    .stereo_i (st),
    .mute_i   (mu),
    .left_o   (left_o),
    .right_o  (right_o),
    .valid_o  (valid_o)
`ifdef PSG_MIXER_DSM_EN
    ,
    .dac_l_o  (dac_l_o),
    .dac_r_o  (dac_r_o)
`endif
  );

  // ---------------------------------------------------------------- model
  function automatic void mix_ref(input int ia, input int ib, input int ic,
                                  input logic [1:0] md, output int l, output int r);
    if (md == 2'b01) begin
      l = 2 * ia + ib; r = 2 * ic + ib;
    end else if (md == 2'b10) begin
      l = 2 * ia + ic; r = 2 * ib + ic;
    end else begin
      l = ia + ib + ic; r = l;
    end
  endfunction

  // ---------------------------------------------------------------- drivers
  // Called at posedge+1; returns at the following posedge+1 with ce low.
  task automatic ce_pulse(input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] ic,
                          input logic [1:0] ist, input logic imu);
    int l, r;
    a = ia; b = ib; c = ic; st = ist; mu = imu; ce = 1'b1;
    @(posedge clk); #1;
    ce = 1'b0;
    if (m_cnt == 0) begin
      m_mode = ist; m_sl = 0; m_sr = 0;
    end
    mix_ref(int'(ia), int'(ib), int'(ic), m_mode, l, r);
    m_sl += l; m_sr += r;
    if (m_cnt == 3) begin
      if (imu) exp_q.push_back(20'd0);
      else     exp_q.push_back({10'(m_sl / 4), 10'(m_sr / 4)});
      m_cnt = 0;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    ce = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = 0; exp_q.delete(); last_l = 10'd0; last_r = 10'd0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    a = 8'hFF; b = 8'hFF; c = 8'hFF; st = 2'b00; mu = 1'b0;
    rst = 1'b1; ce = 1'b1;
    idle(3);
    n_checks++;
    if (left_o !== 10'd0 || right_o !== 10'd0 || valid_o !== 1'b0)
      $display("FAIL reset_state: left=%0d right=%0d valid=%b, required 0/0/0", left_o, right_o, valid_o);
    else n_pass++;
    ce = 1'b0; rst = 1'b0;
    m_cnt = 0; exp_q.delete(); last_l = 10'd0; last_r = 10'd0;
    idle(1);
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL reset_release_valid: valid=%b, required 0", valid_o);
    else n_pass++;
  endtask

  task automatic test_mono_max();
    for (int k = 0; k < 4; k++) begin
      ce_pulse(8'hFF, 8'hFF, 8'hFF, 2'b00, 1'b0);
      n_checks++;
      if (valid_o !== (k == 3)) $display("FAIL mono_max_valid%0d: valid=%b, required %b", k, valid_o, k == 3);
      else n_pass++;
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if (left_o !== 10'd765 || right_o !== 10'd765)
      $display("FAIL mono_max: left=%0d right=%0d, required 765/765", left_o, right_o);
    else n_pass++;
    idle(1);
    n_checks++;
    if (valid_o !== 1'b0) $display("FAIL mono_max_pulse: valid=%b one cycle later, required 0", valid_o);
    else n_pass++;
    last_l = left_o; last_r = right_o;
  endtask

  task automatic test_abc();
    ce_pulse(8'd100, 8'd50, 8'd0, 2'b01, 1'b0);
    ce_pulse(8'd100, 8'd50, 8'd0, 2'b01, 1'b0);
    ce_pulse(8'd0,   8'd50, 8'd0, 2'b01, 1'b0);
    ce_pulse(8'd0,   8'd50, 8'd0, 2'b01, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (valid_o !== 1'b1 || left_o !== 10'd150 || right_o !== 10'd50)
      $display("FAIL abc_avg: valid=%b left=%0d right=%0d, required 1/150/50", valid_o, left_o, right_o);
    else n_pass++;
  endtask

  task automatic test_mode_switch();
    ce_pulse(8'd10, 8'd20, 8'd30, 2'b01, 1'b0);
    ce_pulse(8'd10, 8'd20, 8'd30, 2'b01, 1'b0);
    ce_pulse(8'd10, 8'd20, 8'd30, 2'b10, 1'b0);
    ce_pulse(8'd10, 8'd20, 8'd30, 2'b10, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (left_o !== 10'd40 || right_o !== 10'd80)
      $display("FAIL mode_switch_abc: left=%0d right=%0d, required 40/80", left_o, right_o);
    else n_pass++;
    for (int k = 0; k < 4; k++) ce_pulse(8'd10, 8'd20, 8'd30, 2'b10, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (left_o !== 10'd50 || right_o !== 10'd70)
      $display("FAIL mode_switch_acb: left=%0d right=%0d, required 50/70", left_o, right_o);
    else n_pass++;
  endtask

  task automatic test_mute();
    for (int k = 0; k < 4; k++) ce_pulse(8'hFF, 8'hFF, 8'hFF, 2'b00, k == 3);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (valid_o !== 1'b1 || left_o !== 10'd0 || right_o !== 10'd0)
      $display("FAIL mute_block: valid=%b left=%0d right=%0d, required 1/0/0", valid_o, left_o, right_o);
    else n_pass++;
    for (int k = 0; k < 4; k++) ce_pulse(8'hFF, 8'hFF, 8'hFF, 2'b00, 1'b0);
    exp_v = exp_q.pop_front();
    n_checks++;
    if (left_o !== 10'd765 || right_o !== 10'd765)
      $display("FAIL unmute_block: left=%0d right=%0d, required 765/765", left_o, right_o);
    else n_pass++;
  endtask

  task automatic test_reset_midblock();
    ce_pulse(8'd200, 8'd200, 8'd200, 2'b00, 1'b0);
    ce_pulse(8'd200, 8'd200, 8'd200, 2'b00, 1'b0);
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      ce_pulse(8'd10, 8'd10, 8'd10, 2'b00, 1'b0);
      n_checks++;
      if (valid_o !== (k == 3)) $display("FAIL reset_mid_valid%0d: valid=%b, required %b", k, valid_o, k == 3);
      else n_pass++;
    end
    exp_v = exp_q.pop_front();
    n_checks++;
    if (left_o !== 10'd30 || right_o !== 10'd30)
      $display("FAIL reset_mid_result: left=%0d right=%0d, required 30/30", left_o, right_o);
    else n_pass++;
    last_l = left_o; last_r = right_o;
  endtask

  task automatic test_random();
    int gap;
    for (int blk = 0; blk < 30; blk++) begin
      for (int s = 0; s < 4; s++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          idle(1);
          n_checks++;
          if (valid_o !== 1'b0 || left_o !== last_l || right_o !== last_r)
            $display("FAIL rand_hold: valid=%b left=%0d right=%0d, required 0/%0d/%0d",
                     valid_o, left_o, right_o, last_l, last_r);
          else n_pass++;
        end
        ce_pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        if (s == 3) begin
          exp_v = exp_q.pop_front();
          n_checks++;
          if (valid_o !== 1'b1 || left_o !== exp_v[19:10] || right_o !== exp_v[9:0])
            $display("FAIL rand_block%0d: valid=%b left=%0d right=%0d, required 1/%0d/%0d",
                     blk, valid_o, left_o, right_o, exp_v[19:10], exp_v[9:0]);
          else n_pass++;
          last_l = exp_v[19:10]; last_r = exp_v[9:0];
        end else begin
          n_checks++;
          if (valid_o !== 1'b0) $display("FAIL rand_midblock_valid: valid=%b, required 0", valid_o);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 16; k++) begin
      ce_pulse(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               2'($urandom_range(0, 3)), 1'b0);
      if (k % 4 == 3) begin
        exp_v = exp_q.pop_front();
        n_checks++;
        if (valid_o !== 1'b1 || left_o !== exp_v[19:10] || right_o !== exp_v[9:0])
          $display("FAIL b2b_block%0d: valid=%b left=%0d right=%0d, required 1/%0d/%0d",
                   k / 4, valid_o, left_o, right_o, exp_v[19:10], exp_v[9:0]);
        else n_pass++;
        last_l = exp_v[19:10]; last_r = exp_v[9:0];
      end else begin
        n_checks++;
        if (valid_o !== 1'b0) $display("FAIL b2b_valid%0d: valid=%b, required 0", k, valid_o);
        else n_pass++;
      end
    end
  endtask

`ifdef PSG_MIXER_DSM_EN
  task automatic test_dsm();
    int ones;
    // mono 170+170+172 = 512 per sample -> left = 512
    for (int k = 0; k < 4; k++) ce_pulse(8'd170, 8'd170, 8'd172, 2'b00, 1'b0);
    exp_v = exp_q.pop_front();
    ones = 0;
    for (int k = 0; k < 1024; k++) begin
      idle(1);
      ones += int'(dac_l_o);
    end
    n_checks++;
    if (left_o !== 10'd512 || ones != 512)
      $display("FAIL dsm_half: left=%0d ones=%0d, required 512/512", left_o, ones);
    else n_pass++;
    apply_reset();
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      idle(1);
      ones += int'(dac_l_o);
    end
    n_checks++;
    if (ones != 0) $display("FAIL dsm_zero: ones=%0d, required 0", ones);
    else n_pass++;
  endtask
`endif

  initial begin
    rst = 1'b0; ce = 1'b0; a = 8'd0; b = 8'd0; c = 8'd0; st = 2'b00; mu = 1'b0;
    m_cnt = 0; m_mode = 2'b00; m_sl = 0; m_sr = 0; last_l = 10'd0; last_r = 10'd0;
    exp_v = 20'd0;
    @(posedge clk); #1;
    test_reset();
    test_mono_max();
    test_abc();
    test_mode_switch();
    test_mute();
    test_reset_midblock();
    test_random();
    test_back_to_back();
`ifdef PSG_MIXER_DSM_EN
    test_dsm();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/psg_mixer.md
PSG_MIXER -- requirements
Module: psg_mixer

Interface
REQ-001 CLK  input  1  system clock; every state change on its rising edge.
REQ-002 RESET  input  1  asynchronous, active-high reset.
REQ-003 CE  input  1  sample strobe, one CLK wide; the channels are sampled on each CE.
REQ-004 CH_A, CH_B, CH_C  input  8 each  unsigned per-channel levels from the PSG.
REQ-005 STEREO  input  2  pan mode: 00 mono, 01 ABC, 10 ACB, 11 mono.
REQ-006 MUTE  input  1  forces LEFT/RIGHT to zero at the next block output.
REQ-007 LEFT, RIGHT  output  10 each  unsigned averaged mix, registered.
REQ-008 VALID  output  1  one-CLK pulse when LEFT/RIGHT update.
REQ-009 DAC_L, DAC_R  output  1 each  sigma-delta bitstreams; present only with PSG_MIXER_DSM_EN.

Function
REQ-010 Per-sample mix, computed at 10 bits, no overflow possible (max 765):
- mono: L = R = A+B+C
- ABC: L = 2A+B, R = 2C+B
- ACB: L = 2A+C, R = 2B+C
REQ-011 Block of 4 samples; 2-bit sample counter SCNT advances on each CE and wraps 3->0.
REQ-012 STEREO latched into MODE_Q on a CE with SCNT=0; the whole block uses MODE_Q, so a mid-block STEREO change takes effect at the next block.
REQ-013 12-bit accumulators ACC_L/ACC_R: on CE with SCNT=0 load the sample mix; on CE with SCNT=1..2 add the mix.
REQ-014 On CE with SCNT=3: LEFT <= (ACC_L+mix)>>2 and RIGHT <= (ACC_R+mix)>>2 (truncate), or 0 if MUTE; VALID=1 in the following cycle only.
REQ-015 Output latency: LEFT/RIGHT/VALID are visible one CLK after the 4th CE of a block.
REQ-016 No CE: all state holds; LEFT/RIGHT hold the last value; VALID=0.
REQ-017 MUTE is sampled only on the block-closing CE; the accumulators run regardless of MUTE.
REQ-018 Back-to-back CE (every cycle) is legal; VALID then pulses every 4th cycle.

Reset
REQ-019 RESET asserted: SCNT=0, ACC_L=ACC_R=0, MODE_Q=00, LEFT=RIGHT=0, VALID=0, DSM accumulators=0, DAC_L=DAC_R=0.
REQ-020 RESET mid-block discards the partial block; the first CE after release starts a new block at SCNT=0.
REQ-021 RESET deassertion is glitch-free: no VALID pulse in the release cycle.

Configuration
REQ-022 Macro PSG_MIXER_DSM_EN defined: instantiate a first-order sigma-delta modulator per side.
- Runs every CLK: 11-bit DSM_L <= {1'b0, DSM_L[9:0]} + LEFT; DAC_L = DSM_L[10], registered.
- DAC_R is built the same way from RIGHT.
REQ-023 Macro undefined: DAC_L/DAC_R ports and the DSM logic are absent; all other behaviour is identical.

Verification
REQ-024 Mono, A=B=C=8'hFF, 4 CE -> LEFT=RIGHT=765, VALID one cycle after the 4th CE.
REQ-025 ABC, A=100, B=50, C=0 for samples 1-2, then A=0 for samples 3-4 -> LEFT=(250+250+50+50)/4=150, RIGHT=50.
REQ-026 STEREO switched 01->10 after the 2nd CE of a block -> that block stays ABC; the next block is ACB.
REQ-027 MUTE=1 only on the 4th CE, mono 255s -> LEFT=RIGHT=0; the next block with MUTE=0 gives 765.
REQ-028 RESET pulsed after the 2nd CE, then 4 CE of mono A=B=C=10 -> LEFT=30, with no VALID before the 4th post-reset CE.
REQ-029 PSG_MIXER_DSM_EN, LEFT held at 512 -> DAC_L duty = 512/1024 = 50% over 1024 cycles, alternating pattern; LEFT=0 -> DAC_L constant 0.
